bist_sequencer: RTL and testbench

//  Test-per-scan BIST sequencer that drives the scan-mode self-test of the circuit under test.

---
 rtl/bist_sequencer.sv | 118 +++++++++++
 tb/tb_bist_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// Test-per-scan BIST sequencer: LFSR seed pulse, scan_en shift/capture windows, finish strobe.
// Define BIST_SEQ_ABORT_EN to add the ABORT input that cancels a run in progress.
module bist_sequencer #(
  parameter int CHAIN_LEN  = 15,
  parameter int N_PATTERNS = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic START,
`ifdef BIST_SEQ_ABORT_EN
  input  logic ABORT,
`endif
  output logic OUT,
  output logic SEED,
  output logic FINISH,
  output logic BIST_END,
  output logic RUNNING
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [SW-1:0] LAST_SHIFT = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_TOTAL  = PW'(N_PATTERNS);

  // S_FINISH is the one-cycle entry into the done phase; S_DONE holds BIST_END while START stays high.
  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SHIFT, S_CAPTURE, S_FINISH, S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [SW-1:0] r_shift_cnt, w_shift_next;
  logic [PW-1:0] r_pat_cnt, w_pat_next;
  logic          r_start_q;
  logic          r_out, r_seed, r_finish, r_bist_end, r_running;
  logic          w_rise;
  logic          w_abort;

`ifdef BIST_SEQ_ABORT_EN
  assign w_abort = ABORT;
`else
  assign w_abort = 1'b0;
`endif

  assign w_rise = START & ~r_start_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    w_shift_next = r_shift_cnt;
    w_pat_next   = r_pat_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_next = S_SEED;
      end
      S_SEED: begin
        w_state_next = S_SHIFT;
        w_shift_next = '0;
        w_pat_next   = '0;
      end
      S_SHIFT: begin
        if (r_shift_cnt == LAST_SHIFT) begin
          w_shift_next = '0;
          w_state_next = (r_pat_cnt < PAT_TOTAL) ? S_CAPTURE : S_FINISH;
        end else begin
          w_shift_next = r_shift_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_pat_next   = r_pat_cnt + 1'b1;
        w_shift_next = '0;
        w_state_next = S_SHIFT;
      end
      S_FINISH, S_DONE: begin
        w_state_next = START ? S_DONE : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_abort && (r_state inside {S_SEED, S_SHIFT, S_CAPTURE})) begin
      w_state_next = S_IDLE;
      w_shift_next = '0;
      w_pat_next   = '0;
    end
  end

  // Outputs are flops loaded from the next-state decode, so they line up with the state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_start_q   <= 1'b0;
      r_out       <= 1'b0;
      r_seed      <= 1'b0;
      r_finish    <= 1'b0;
      r_bist_end  <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift_cnt <= w_shift_next;
      r_pat_cnt   <= w_pat_next;
      r_start_q   <= START;
      r_out       <= (w_state_next == S_SHIFT);
      r_seed      <= (w_state_next == S_SEED);
      r_finish    <= (w_state_next == S_FINISH);
      r_bist_end  <= (w_state_next inside {S_FINISH, S_DONE});
      r_running   <= (w_state_next inside {S_SEED, S_SHIFT, S_CAPTURE});
    end
  end

  assign OUT      = r_out;
  assign SEED     = r_seed;
  assign FINISH   = r_finish;
  assign BIST_END = r_bist_end;
  assign RUNNING  = r_running;

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: directed vector table, multi-cycle run sequences,
// and randomized START/RST/ABORT traffic compared against a cycle-count reference model.
module tb_bist_sequencer;

  localparam int C     = 4;
  localparam int N     = 3;
  localparam int TOTAL = 1 + C + N * (C + 1);

`ifdef BIST_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic CLK = 1'b0;
  logic RST;
  logic START;
`ifdef BIST_SEQ_ABORT_EN
  logic ABORT;
`endif
  logic OUT, SEED, FINISH, BIST_END, RUNNING;

  int n_tests = 0;
  int n_fail  = 0;

  int   m_mode = M_IDLE;
  int   m_k    = 0;
  logic m_prev = 1'b0;

  always #5 CLK = ~CLK;

  bist_sequencer #(.CHAIN_LEN(C), .N_PATTERNS(N)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
`ifdef BIST_SEQ_ABORT_EN
    .ABORT    (ABORT),
`endif
    .OUT      (OUT),
    .SEED     (SEED),
    .FINISH   (FINISH),
    .BIST_END (BIST_END),
    .RUNNING  (RUNNING)
  );

  // Output vector order everywhere: {OUT, SEED, FINISH, BIST_END, RUNNING}
  function automatic logic [4:0] got();
    return {OUT, SEED, FINISH, BIST_END, RUNNING};
  endfunction

  // Reference: a run is a cycle index k counted from the SEED cycle (k=0); after the seed come
  // C shift cycles, then N groups of {capture, C shifts}; k==TOTAL is the FINISH cycle.
  function automatic logic [4:0] model_exp();
    logic o, s, f, b, r;
    int   p;
    o = 1'b0; s = 1'b0; f = 1'b0; b = 1'b0; r = 1'b0;
    if (m_mode == M_RUN) begin
      if (m_k == TOTAL) begin
        f = 1'b1;
        b = 1'b1;
      end else begin
        r = 1'b1;
        s = (m_k == 0);
        if (m_k > 0) begin
          p = m_k - 1;
          o = (p < C) || (((p - C) % (C + 1)) != 0);
        end
      end
    end else if (m_mode == M_HOLD) begin
      b = 1'b1;
    end
    return {o, s, f, b, r};
  endfunction

  task automatic model_step(input logic rst, input logic start, input logic abort);
    logic rise;
    logic ab;
    ab = abort && ABORT_EN;
    if (rst) begin
      m_mode = M_IDLE;
      m_k    = 0;
      m_prev = 1'b0;
    end else begin
      rise   = start && !m_prev;
      m_prev = start;
      case (m_mode)
        M_IDLE: if (rise) begin m_mode = M_RUN; m_k = 0; end
        M_RUN: begin
          if (m_k == TOTAL)  m_mode = start ? M_HOLD : M_IDLE;
          else if (ab)       m_mode = M_IDLE;
          else               m_k++;
        end
        M_HOLD: if (!start) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Drive inputs between edges, clock once, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic start, input logic abort);
    RST   = rst;
    START = start;
`ifdef BIST_SEQ_ABORT_EN
    ABORT = abort;
`endif
    @(posedge CLK);
    model_step(rst, start, abort);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {OUT,SEED,FINISH,BIST_END,RUNNING}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[12];

  // One full run from IDLE with START low; START is held, dropped, or re-pulsed at retrig_at.
  task automatic run_check(input string tag, input logic hold, input int retrig_at);
    int         fin_at;
    int         outs;
    int         caps;
    int         seeds;
    logic       prev_out;
    logic       s;
    logic [4:0] g;
    fin_at   = -1;
    outs     = 0;
    caps     = 0;
    seeds    = 0;
    prev_out = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check({tag, "_idle"}, got(), 5'b00000);
    step(1'b0, 1'b1, 1'b0);
    check({tag, "_seed"}, got(), 5'b01001);
    for (int i = 1; i <= TOTAL + 10; i++) begin
      s = hold;
      if (retrig_at > 0 && i == retrig_at - 1) s = 1'b0;
      if (retrig_at > 0 && i == retrig_at)     s = 1'b1;
      step(1'b0, s, 1'b0);
      g = got();
      if (g[3]) seeds++;
      if (g[4]) outs++;
      if (prev_out && !g[4] && g[0]) caps++;
      prev_out = g[4];
      if (g[2]) begin
        fin_at = i;
        check({tag, "_finish_vec"}, g, 5'b00110);
        break;
      end
    end
    check_int({tag, "_finish_cycle_after_seed"}, fin_at, TOTAL);
    check_int({tag, "_out_high_cycles"}, outs, C + N * C);
    check_int({tag, "_captures"}, caps, N);
    check_int({tag, "_extra_seed"}, seeds, 0);
    if (hold) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 1'b1, 1'b0);
        check({tag, "_bist_end_hold"}, got(), 5'b00010);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    check({tag, "_release"}, got(), 5'b00000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] g;
    int         seen;
    logic       r_in, s_in, a_in;

    // Reset for 3 cycles, start a run, then reset mid-SHIFT.
    tbl[0]  = '{1'b1, 1'b0, 5'b00000};
    tbl[1]  = '{1'b1, 1'b0, 5'b00000};
    tbl[2]  = '{1'b1, 1'b0, 5'b00000};
    tbl[3]  = '{1'b0, 1'b0, 5'b00000};
    tbl[4]  = '{1'b0, 1'b1, 5'b01001};
    tbl[5]  = '{1'b0, 1'b1, 5'b10001};
    tbl[6]  = '{1'b0, 1'b0, 5'b10001};
    tbl[7]  = '{1'b0, 1'b0, 5'b10001};
    tbl[8]  = '{1'b0, 1'b0, 5'b10001};
    tbl[9]  = '{1'b0, 1'b0, 5'b00001};
    tbl[10] = '{1'b0, 1'b0, 5'b10001};
    tbl[11] = '{1'b1, 1'b1, 5'b00000};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].start, 1'b0);
      check($sformatf("vec%0d", i), got(), tbl[i].exp);
    end

    run_check("run_hold",    1'b1, 0);
    run_check("run_drop",    1'b0, 0);
    run_check("run_retrig",  1'b1, 8);

`ifdef BIST_SEQ_ABORT_EN
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 1'b0);
    check("abort_pre_running", got(), 5'b10001);
    step(1'b0, 1'b1, 1'b1);
    check("abort_idle", got(), 5'b00000);
    seen = 0;
    for (int i = 0; i < TOTAL + 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      g = got();
      if (g[2] || g[1] || g[0]) seen++;
    end
    check_int("abort_no_finish_or_retrigger", seen, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("abort_restart_seed", got(), 5'b01001);
`endif

    step(1'b1, 1'b0, 1'b0);
    check("rand_sync_reset", got(), model_exp());
    s_in = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r_in = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) s_in = ~s_in;
      a_in = ($urandom_range(0, 59) == 0);
      step(r_in, s_in, a_in);
      check($sformatf("rand%0d", i), got(), model_exp());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
